// File: rtl/blake2_pkg.sv
// +---------------------------------------------------------------------------+
// | blake2_pkg: shared sizes, state encoding and byte-count helper for the    |
// | BLAKE2b message packer.                      Rev 1.0                      |
// +---------------------------------------------------------------------------+
`default_nettype none

package blake2_pkg;

  localparam int W    = 64;
  localparam int BB   = 128;
  localparam int NW   = BB * 8 / W;
  localparam int WB   = W / 8;
  localparam int KW   = $clog2(NW);
  localparam int LENW = 8;
  localparam int BCW  = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Byte counts of 0 or above a full word both mean a full word.
  function automatic logic [BCW-1:0] eff_bytes(input logic [BCW-1:0] b);
    return (b == '0 || b > BCW'(WB)) ? BCW'(WB) : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blake2_byte_mask.sv
// +---------------------------------------------------------------------------+
// | blake2_byte_mask: maps a valid-byte count onto a per-bit keep mask for    |
// | one stream word.                             Rev 1.0                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module blake2_byte_mask
  import blake2_pkg::*;
(
  input  logic [BCW-1:0] bytes_i,
  output logic [W-1:0]   mask_o
);

  logic [BCW-1:0] eff;

  assign eff = eff_bytes(bytes_i);

  for (genvar i = 0; i < WB; i++) begin : g_byte
    assign mask_o[i*8 +: 8] = (BCW'(i) < eff) ? 8'hFF : 8'h00;
  end

endmodule

`default_nettype wire

// File: rtl/blake2b_msg_packer.sv
// +---------------------------------------------------------------------------+
// | blake2b_msg_packer: packs a 64-bit word stream into one zero-padded       |
// | 1024-bit BLAKE2b block and holds it until the core finishes. Rev 1.0      |
// +---------------------------------------------------------------------------+
`default_nettype none

module blake2b_msg_packer
  import blake2_pkg::*;
(
  input  logic            clk,
  input  logic            nreset,
  input  logic            s_valid_i,
  input  logic [W-1:0]    s_data_i,
  input  logic            s_last_i,
  input  logic [BCW-1:0]  s_bytes_i,
  output logic            s_ready_o,
  output logic            block_v_o,
  output logic [BB*8-1:0] block_o,
  output logic [LENW-1:0] msg_bytes_o,
  input  logic            hash_v_i,
  output logic            err_o
);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BB*8-1:0] buf_q, buf_d;
  logic [LENW-1:0] msg_bytes_q, msg_bytes_d;
  logic            err_q, err_d;

  logic [W-1:0]    keep_mask;
  logic [BCW-1:0]  last_bytes;
  logic            overflow;

  blake2_byte_mask u_mask (
    .bytes_i (s_bytes_i),
    .mask_o  (keep_mask)
  );

  assign last_bytes = eff_bytes(s_bytes_i);
  assign overflow   = (k_q == KW'(NW - 1)) && !s_last_i;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    buf_d       = buf_q;
    msg_bytes_d = msg_bytes_q;
    err_d       = err_q;
    s_ready_o   = 1'b0;
    block_v_o   = 1'b0;

    unique case (state_q)
      FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          buf_d[int'(k_q)*W +: W] = s_last_i ? (s_data_i & keep_mask) : s_data_i;
          k_d = k_q + KW'(1);
          // A full block without a last marker is closed as a full word.
          if (s_last_i || overflow) begin
            msg_bytes_d = {1'b0, k_q, 3'b000}
                        + {4'b0000, (s_last_i ? last_bytes : BCW'(WB))};
            err_d       = err_q | overflow;
            state_d     = EMIT;
          end
        end
      end
      EMIT: begin
        block_v_o = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (hash_v_i) begin
          buf_d   = '0;
          k_d     = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= FILL;
      k_q         <= '0;
      buf_q       <= '0;
      msg_bytes_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      msg_bytes_q <= msg_bytes_d;
      err_q       <= err_d;
    end
  end

  assign block_o     = buf_q;
  assign msg_bytes_o = msg_bytes_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_blake2b_msg_packer.sv
// +---------------------------------------------------------------------------+
// | tb_blake2b_msg_packer: directed stimulus with a block scoreboard for the  |
// | BLAKE2b message packer.                      Rev 1.0                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_blake2b_msg_packer;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           s_valid_i = 1'b0;
  logic [63:0]    s_data_i = '0;
  logic           s_last_i = 1'b0;
  logic [3:0]     s_bytes_i = '0;
  logic           s_ready_o;
  logic           block_v_o;
  logic [1023:0]  block_o;
  logic [7:0]     msg_bytes_o;
  logic           hash_v_i = 1'b0;
  logic           err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1023:0] blk;
    logic [7:0]    nb;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  blake2b_msg_packer dut (
    .clk         (clk),
    .nreset      (nreset),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .s_bytes_i   (s_bytes_i),
    .s_ready_o   (s_ready_o),
    .block_v_o   (block_v_o),
    .block_o     (block_o),
    .msg_bytes_o (msg_bytes_o),
    .hash_v_i    (hash_v_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every block pulse must match the oldest expected block.
  always @(negedge clk) begin
    if (block_v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("block", block_o, e.blk);
        chk("msg_bytes", 1024'(msg_bytes_o), 1024'(e.nb));
        chk("err", 1024'(err_o), 1024'(e.err));
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    s_bytes_i = nb;
    chk("ready_fill", 1024'(s_ready_o), 1024'(1));
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // Called right after the final word: checks the EMIT pulse and WAIT stall,
  // then releases with hash_v_i and checks the cleared buffer.
  task automatic finish_block();
    chk("block_v_n1", 1024'(block_v_o), 1024'(1));
    chk("ready_emit", 1024'(s_ready_o), 1024'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("block_v_low", 1024'(block_v_o), 1024'(0));
      chk("ready_wait", 1024'(s_ready_o), 1024'(0));
    end
    hash_v_i = 1'b1;
    @(posedge clk); #1;
    hash_v_i = 1'b0;
    chk("ready_release", 1024'(s_ready_o), 1024'(1));
    chk("buf_cleared", block_o, 1024'(0));
  endtask

  initial begin
    exp_t e;
    logic [1023:0] blk;

    #12;
    chk("rst_ready", 1024'(s_ready_o), 1024'(1));
    chk("rst_block_v", 1024'(block_v_o), 1024'(0));
    chk("rst_block", block_o, 1024'(0));
    chk("rst_msg_bytes", 1024'(msg_bytes_o), 1024'(0));
    chk("rst_err", 1024'(err_o), 1024'(0));
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    // Single 3-byte word.
    e.blk = '0; e.blk[63:0] = 64'h0000_0000_0066_7788; e.nb = 8'd3; e.err = 1'b0;
    exp_q.push_back(e);
    send_word(64'h1122334455667788, 1'b1, 4'd3);
    finish_block();

    // Full block terminated on word 15.
    blk = '0;
    for (int i = 0; i < 16; i++) blk[i*64 +: 64] = 64'(i);
    e.blk = blk; e.nb = 8'd128; e.err = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) send_word(64'(i), (i == 15), 4'd8);
    finish_block();

    // Full block without a last marker: overflow.
    e.blk = blk; e.nb = 8'd128; e.err = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) send_word(64'(i), 1'b0, 4'd0);
    finish_block();

    // Back-to-back messages; second must carry no residue.
    blk = '0;
    for (int i = 0; i < 5; i++) blk[i*64 +: 64] = 64'hF0F0_0000_0000_0000 | 64'(i + 1);
    e.blk = blk; e.nb = 8'd40; e.err = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) send_word(64'hF0F0_0000_0000_0000 | 64'(i + 1), (i == 4), 4'd8);
    finish_block();
    blk = '0;
    blk[63:0]   = 64'hA1A2_A3A4_A5A6_A7A8;
    blk[127:64] = 64'hB1B2_B3B4_B5B6_B7B8;
    e.blk = blk; e.nb = 8'd16; e.err = 1'b1;
    exp_q.push_back(e);
    send_word(64'hA1A2_A3A4_A5A6_A7A8, 1'b0, 4'd8);
    send_word(64'hB1B2_B3B4_B5B6_B7B8, 1'b1, 4'd8);
    finish_block();

    // hash_v_i in FILL and EMIT must have no effect.
    blk = '0;
    blk[63:0]   = 64'h0123_4567_89AB_CDEF;
    blk[127:64] = 64'h0000_0000_0000_00CC;
    e.blk = blk; e.nb = 8'd9; e.err = 1'b1;
    exp_q.push_back(e);
    send_word(64'h0123_4567_89AB_CDEF, 1'b0, 4'd8);
    hash_v_i = 1'b1;
    @(posedge clk); #1;
    hash_v_i = 1'b0;
    chk("hash_in_fill_ready", 1024'(s_ready_o), 1024'(1));
    chk("hash_in_fill_buf", 1024'(block_o[63:0]), 1024'(64'h0123_4567_89AB_CDEF));
    send_word(64'hDDDD_DDDD_DDDD_DDCC, 1'b1, 4'd1);
    hash_v_i = 1'b1;
    @(posedge clk); #1;
    hash_v_i = 1'b0;
    chk("hash_in_emit_ready", 1024'(s_ready_o), 1024'(0));
    chk("hash_in_emit_bv", 1024'(block_v_o), 1024'(0));
    @(posedge clk); #1;
    chk("still_wait", 1024'(s_ready_o), 1024'(0));
    hash_v_i = 1'b1;
    @(posedge clk); #1;
    hash_v_i = 1'b0;
    chk("wait_release", 1024'(s_ready_o), 1024'(1));

    // Reset after three words: no block, outputs back to reset values.
    for (int i = 0; i < 3; i++) send_word(64'h5555_0000_0000_0000 | 64'(i), 1'b0, 4'd8);
    nreset = 1'b0;
    #1;
    chk("mid_rst_ready", 1024'(s_ready_o), 1024'(1));
    chk("mid_rst_block", block_o, 1024'(0));
    chk("mid_rst_msg_bytes", 1024'(msg_bytes_o), 1024'(0));
    chk("mid_rst_err", 1024'(err_o), 1024'(0));
    @(posedge clk); #1;
    chk("mid_rst_block_v", 1024'(block_v_o), 1024'(0));
    nreset = 1'b1;
    @(posedge clk); #1;
    e.blk = '0; e.blk[63:0] = 64'h0000_00DD_EEFF_0011; e.nb = 8'd5; e.err = 1'b0;
    exp_q.push_back(e);
    send_word(64'hAABB_CCDD_EEFF_0011, 1'b1, 4'd5);
    finish_block();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 1024'(exp_q.size()), 1024'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
